// File: rtl/prio_drain_pkg.sv
// Shared types and helpers for the draining priority encoder.
// Service direction follows PRIO_DRAIN_LSB_FIRST_EN (defined: lowest index first).
package prio_drain_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

`ifdef PRIO_DRAIN_LSB_FIRST_EN
   localparam bit LSB_FIRST = 1'b1;
`else
   localparam bit LSB_FIRST = 1'b0;
`endif

   // True when exactly one bit is set; vectors narrower than 64 are zero-extended.
   function automatic logic is_one_hot(input logic [63:0] v);
      return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
   endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational WIDTH-to-IDX_W priority encoder with selectable direction.
// code is 0 when no bit is set; any_set distinguishes that case from index 0.
module prio_enc_n #(
   parameter int WIDTH     = 8,
   parameter int IDX_W     = $clog2(WIDTH),
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] code,
   output logic             any_set
);

   // The last matching bit in scan order wins, so scan away from the winning end.
   always_comb begin
      code    = '0;
      any_set = |vec;
      if (LSB_FIRST) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) code = IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) code = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/prio_drain_encoder.sv
// Sequential priority encoder: accepts a request vector, then emits one index per beat
// until drained. Order set by PRIO_DRAIN_LSB_FIRST_EN (undefined: highest index first).
module prio_drain_encoder
   import prio_drain_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_code,
   output logic             out_last,
   output logic             out_none,
   output logic             busy
);

   // state | meaning
   // IDLE  | no vector held; in_ready follows en
   // DRAIN | pending/none hold the vector; one beat presented per cycle

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic             none_q, none_d;
   logic [IDX_W-1:0] enc_code;
   logic             enc_any;
   logic             beat_last;
   logic             accept;
   logic             take;

   prio_enc_n #(
      .WIDTH     (WIDTH),
      .IDX_W     (IDX_W),
      .LSB_FIRST (LSB_FIRST)
   ) u_enc (
      .vec     (pending_q),
      .code    (enc_code),
      .any_set (enc_any)
   );

   assign beat_last = none_q || is_one_hot(64'(pending_q));
   assign accept    = in_valid && in_ready;
   // A beat presented while en is low is discarded, not consumed.
   assign take      = en && out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         none_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         none_q    <= none_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      none_d    = none_q;
      if (!en) begin
         state_d   = IDLE;
         pending_d = '0;
         none_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_d   = DRAIN;
                  pending_d = in_vec;
                  none_d    = (in_vec == '0);
               end
            end
            DRAIN: begin
               if (take) begin
                  if (enc_any) pending_d[enc_code] = 1'b0;
                  if (beat_last) begin
                     state_d = IDLE;
                     none_d  = 1'b0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_code  = '0;
      out_last  = 1'b0;
      out_none  = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = en;
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_code  = enc_code;
            out_last  = beat_last;
            out_none  = none_q;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_prio_drain_encoder.sv
// Self-checking bench for prio_drain_encoder (WIDTH=8): table vectors, hand sequences,
// and randomized vectors/back-pressure against a list-of-beats reference model.
module tb_prio_drain_encoder;

   localparam int WIDTH = 8;
   localparam int IDX_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_vec;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_code;
   logic             out_last;
   logic             out_none;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   prio_drain_encoder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_last  (out_last),
      .out_none  (out_none),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   code;
      logic last;
      logic none;
   } beat_t;

   typedef struct {
      logic [WIDTH-1:0] vec;
      int               n_beats;
      int               first_code;
      int               last_code;
      logic             none;
   } vector_t;

   beat_t exp_q[$];

   // Observed results of the most recent drain.
   int   obs_beats;
   int   obs_first;
   int   obs_lastcode;
   int   obs_cycles;
   logic obs_none;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: indices of set bits in service order; an empty vector yields one none-beat.
   task automatic build_model(input logic [WIDTH-1:0] v);
      int idx[$];
      beat_t b;
      exp_q.delete();
`ifdef PRIO_DRAIN_LSB_FIRST_EN
      for (int i = 0; i < WIDTH; i++) if (v[i]) idx.push_back(i);
`else
      for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) idx.push_back(i);
`endif
      if (idx.size() == 0) begin
         b.code = 0; b.last = 1'b1; b.none = 1'b1;
         exp_q.push_back(b);
      end else begin
         foreach (idx[k]) begin
            b.code = idx[k];
            b.last = (k == idx.size() - 1);
            b.none = 1'b0;
            exp_q.push_back(b);
         end
      end
   endtask

   // Called at a negedge; returns at the negedge after acceptance (first drain cycle).
   task automatic send_vec(input logic [WIDTH-1:0] v);
      int waited = 0;
      build_model(v);
      in_valid = 1'b1;
      in_vec   = v;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk("accept_timeout", int'(waited < 50), 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_vec   = WIDTH'($urandom);
   endtask

   // mode 0: out_ready always 1; 1: toggles 1/0; 2: random.
   task automatic drain(input int mode);
      int   cyc = 0;
      logic r;
      logic prev_stall = 1'b0;
      int   prev_code = 0;
      obs_beats = 0; obs_first = -1; obs_lastcode = -1; obs_none = 1'b0;
      while (exp_q.size() > 0 && cyc < 200) begin
         chk("out_valid_drain", int'(out_valid), 1);
         chk("busy_drain", int'(busy), 1);
         chk("in_ready_drain", int'(in_ready), 0);
         chk("out_code", int'(out_code), exp_q[0].code);
         chk("out_last", int'(out_last), int'(exp_q[0].last));
         chk("out_none", int'(out_none), int'(exp_q[0].none));
         if (prev_stall) chk("stall_stable", int'(out_code), prev_code);
         case (mode)
            0:       r = 1'b1;
            1:       r = (cyc % 2 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         out_ready  = r;
         prev_stall = out_valid && !r;
         prev_code  = int'(out_code);
         if (r && out_valid) begin
            if (obs_beats == 0) obs_first = int'(out_code);
            obs_lastcode = int'(out_code);
            obs_none     = out_none;
            obs_beats++;
            void'(exp_q.pop_front());
         end
         @(negedge clk);
         cyc++;
      end
      chk("drain_timeout", int'(cyc < 200), 1);
      obs_cycles = cyc;
      out_ready  = 1'b0;
      chk("idle_gap_valid", int'(out_valid), 0);
      chk("idle_gap_ready", int'(in_ready), 1);
   endtask

   vector_t tbl[6];

   initial begin
      tbl[0] = '{8'b1010_0100, 3, 7, 2, 1'b0};
      tbl[1] = '{8'h00,        1, 0, 0, 1'b1};
      tbl[2] = '{8'hFF,        8, 7, 0, 1'b0};
      tbl[3] = '{8'h01,        1, 0, 0, 1'b0};
      tbl[4] = '{8'h80,        1, 7, 7, 1'b0};
      tbl[5] = '{8'b0001_1000, 2, 4, 3, 1'b0};

      rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
      #12;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_code", int'(out_code), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_out_none", int'(out_none), 0);
      chk("rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("en0_in_ready", int'(in_ready), 0);
      en = 1'b1;
      @(negedge clk);
      chk("en1_in_ready", int'(in_ready), 1);

      // Table vectors with out_ready held high; 8'hFF repeated with toggling ready.
      for (int t = 0; t < 6; t++) begin
         send_vec(tbl[t].vec);
         drain(0);
         chk("tbl_beats", obs_beats, tbl[t].n_beats);
         chk("tbl_first", obs_first, tbl[t].first_code);
         chk("tbl_last", obs_lastcode, tbl[t].last_code);
         chk("tbl_none", int'(obs_none), int'(tbl[t].none));
         chk("tbl_cycles", obs_cycles, tbl[t].n_beats);
      end
      send_vec(8'hFF);
      drain(1);
      chk("ff_toggle_beats", obs_beats, 8);
      chk("ff_toggle_cycles", obs_cycles, 15);

      // en dropped after first beat of 8'b0001_1000: code 3 is discarded.
      send_vec(8'b0001_1000);
      chk("en_first_code", int'(out_code), 4);
      out_ready = 1'b1;
      @(negedge clk);
      chk("en_second_code", int'(out_code), 3);
      en = 1'b0;
      @(negedge clk);
      chk("en_drop_valid", int'(out_valid), 0);
      chk("en_drop_busy", int'(busy), 0);
      chk("en_drop_in_ready", int'(in_ready), 0);
      en = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      chk("en_back_in_ready", int'(in_ready), 1);
      chk("en_back_valid", int'(out_valid), 0);
      chk("en_pending_clear", int'(dut.pending_q), 0);

      // Asynchronous reset mid-drain.
      send_vec(8'hFF);
      out_ready = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", int'(out_valid), 0);
      chk("async_rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", int'(in_ready), 1);
      chk("post_rst_valid", int'(out_valid), 0);
      chk("post_rst_busy", int'(busy), 0);

      // Randomized vectors and back-pressure.
      for (int n = 0; n < 40; n++) begin
         logic [WIDTH-1:0] v;
         v = (n % 8 == 0) ? '0 : WIDTH'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send_vec(v);
         drain(2);
         chk("rand_beats", obs_beats, (v == 0) ? 1 : $countones(v));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

endmodule
